// File: rtl/ram_checker.sv
// RAM read-back verifier: walks the full address range and
// checks every word against the incremental/decremental fill.
module ram_checker #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19,
  parameter int MAX_OUTST = 4,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_inc,
  input  logic              chk_dec,
  output logic              check_active,
  output logic              check_done,
  output logic              check_pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic [ADDR_W-1:0] addr,
  output logic              ren,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid
);

  localparam int OW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] rx_q, rx_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic              dec_q, dec_d;
  logic              done_q, done_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;

  logic              accept;
  logic              rv_ok;
  logic              mism;
  logic [DATA_W-1:0] exp_w;

  assign ren = (state_q == ISSUE) &&
               (outst_q < OW'(MAX_OUTST));
  assign accept = ren & rd_ready;
  // Responses with nothing outstanding are strays.
  assign rv_ok = rvalid && (state_q != IDLE) &&
                 (outst_q != '0);
  assign exp_w = dec_q ? ~DATA_W'(rx_q) : DATA_W'(rx_q);
  assign mism  = rdata != exp_w;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dec_d   = dec_q;
    done_d  = done_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    outst_d = outst_q + OW'(accept) - OW'(rv_ok);
    unique case (state_q)
      IDLE: begin
        if (chk_inc | chk_dec) begin
          state_d = ISSUE;
          dec_d   = ~chk_inc;
          done_d  = 1'b0;
          err_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
          tx_d    = '0;
          rx_d    = '0;
          outst_d = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          tx_d = tx_q + 1'b1;
          if (tx_q == '1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outst_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rv_ok) begin
      rx_d = rx_q + 1'b1;
      if (mism) begin
        if (err_q != '1) err_d = err_q + 1'b1;
        if (err_q == '0) begin
          fa_d = rx_q;
          fd_d = rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      outst_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      outst_q <= outst_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  assign check_active   = state_q != IDLE;
  assign check_done     = done_q;
  assign check_pass     = done_q & (err_q == '0);
  assign err_cnt        = err_q;
  assign first_err_addr = fa_q;
  assign first_err_data = fd_q;
  assign addr           = tx_q;

endmodule

// File: tb/tb_ram_checker.sv
// Directed bench for ram_checker with an in-order RAM model
// and a scoreboard of expected check results.
module tb_ram_checker;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int MO = 4;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          chk_inc = 1'b0;
  logic          chk_dec = 1'b0;
  logic          check_active;
  logic          check_done;
  logic          check_pass;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;
  logic [AW-1:0] addr;
  logic          ren;
  logic          rd_ready;
  logic [DW-1:0] rdata;
  logic          rvalid;

  ram_checker #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_OUTST(MO), .ERR_W(EW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .chk_inc(chk_inc), .chk_dec(chk_dec),
    .check_active(check_active), .check_done(check_done),
    .check_pass(check_pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_data(first_err_data),
    .addr(addr), .ren(ren), .rd_ready(rd_ready),
    .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int due;
  } req_t;

  typedef struct {
    logic [EW-1:0] err;
    logic          pass;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
  } exp_t;

  logic [DW-1:0] mem [16];
  req_t          pq [$];
  exp_t          sb [$];
  bit            rdy_rand = 1'b0;
  bit            stray_req = 1'b0;
  int            k = 0;
  int            last_due = 0;
  int            outst_viol = 0;
  int            stab_viol = 0;
  int            ord_viol = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] prev_addr = '0;
  bit            prev_stall = 1'b0;
  int            ncmp = 0;
  int            nfail = 0;
  int            last_n = 0;

  // RAM model: in-order responses, 1..6 or fixed 2 cycle latency.
  always @(negedge clk) begin
    int lat;
    int due;
    k++;
    if (!rst_n) begin
      pq.delete();
      rvalid = 1'b0;
      rdata = '0;
      rd_ready = 1'b1;
      prev_stall = 1'b0;
      exp_addr = '0;
    end else begin
      if (pq.size() > MO) outst_viol++;
      if (prev_stall && (!ren || addr != prev_addr))
        stab_viol++;
      rvalid = 1'b0;
      rdata = '0;
      if (pq.size() > 0 && pq[0].due <= k) begin
        rvalid = 1'b1;
        rdata = mem[pq[0].a];
        void'(pq.pop_front());
      end else if (stray_req) begin
        rvalid = 1'b1;
        rdata = 16'hDEAD;
      end
      rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ren && rd_ready) begin
        if (addr != exp_addr) ord_viol++;
        exp_addr = exp_addr + 1'b1;
        lat = rdy_rand ? int'($urandom_range(1, 6)) : 2;
        due = k + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pq.push_back('{a: int'(addr), due: due});
      end
      prev_stall = ren && !rd_ready;
      prev_addr = addr;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill(input bit inc);
    for (int i = 0; i < 16; i++)
      mem[i] = inc ? DW'(i) : ~DW'(i);
  endtask

  function automatic exp_t model(input bit inc);
    exp_t e;
    logic [DW-1:0] p;
    e.err = '0;
    e.fa = '0;
    e.fd = '0;
    for (int a = 0; a < 16; a++) begin
      p = inc ? DW'(a) : ~DW'(a);
      if (mem[a] !== p) begin
        if (e.err == '0) begin
          e.fa = AW'(a);
          e.fd = mem[a];
        end
        if (e.err != '1) e.err = e.err + 1'b1;
      end
    end
    e.pass = (e.err == '0);
    return e;
  endfunction

  task automatic run_check(input logic inc, input logic dec,
                           input bit pulses, input int budget);
    exp_t e;
    int n;
    sb.push_back(model(inc));
    chk_inc = inc;
    chk_dec = dec;
    @(negedge clk);
    chk_inc = 1'b0;
    chk_dec = 1'b0;
    check("start_active", 32'(check_active), 1);
    check("start_ren", 32'(ren), 1);
    check("start_addr", 32'(addr), 0);
    check("start_done", 32'(check_done), 0);
    n = 1;
    while (!check_done && n < budget) begin
      chk_dec = pulses && (n == 5 || n == 9);
      @(negedge clk);
      n++;
    end
    chk_dec = 1'b0;
    check("done", 32'(check_done), 1);
    e = sb.pop_front();
    check("active_end", 32'(check_active), 0);
    check("err_cnt", 32'(err_cnt), 32'(e.err));
    check("pass", 32'(check_pass), 32'(e.pass));
    check("first_addr", 32'(first_err_addr), 32'(e.fa));
    check("first_data", 32'(first_err_data), 32'(e.fd));
    last_n = n;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_active"}, 32'(check_active), 0);
    check({tag, "_done"}, 32'(check_done), 0);
    check({tag, "_pass"}, 32'(check_pass), 0);
    check({tag, "_err"}, 32'(err_cnt), 0);
    check({tag, "_fa"}, 32'(first_err_addr), 0);
    check({tag, "_fd"}, 32'(first_err_data), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_ren"}, 32'(ren), 0);
  endtask

  initial begin
    int n;
    fill(1'b1);
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_check(1'b1, 1'b0, 1'b0, 200);
    check("latency", 32'(last_n <= 16 + MO + 4), 1);

    fill(1'b0);
    run_check(1'b0, 1'b1, 1'b0, 200);
    run_check(1'b1, 1'b0, 1'b0, 200);

    fill(1'b1);
    mem[9] = 16'h1234;
    run_check(1'b1, 1'b0, 1'b0, 200);

    mem[9] = 16'h0009;
    rdy_rand = 1'b1;
    run_check(1'b1, 1'b0, 1'b0, 400);
    run_check(1'b1, 1'b0, 1'b0, 400);
    rdy_rand = 1'b0;
    repeat (2) @(negedge clk);
    check("outst_bound", 32'(outst_viol), 0);
    check("addr_stable", 32'(stab_viol), 0);

    run_check(1'b1, 1'b1, 1'b1, 200);

    mem[2] = 16'hBEEF;
    chk_inc = 1'b1;
    @(negedge clk);
    chk_inc = 1'b0;
    n = 0;
    while (addr != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr7", 32'(addr), 7);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    mem[2] = 16'h0002;
    rst_n = 1'b1;
    @(negedge clk);
    run_check(1'b1, 1'b0, 1'b0, 200);

    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_err", 32'(err_cnt), 0);
    check("stray_done", 32'(check_done), 1);
    check("stray_pass", 32'(check_pass), 1);
    check("stray_active", 32'(check_active), 0);
    check("addr_order", 32'(ord_viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
